// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches and
// queues returned words for decode; taken branches redirect and flush the wrong path.
module fetch_unit #(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter int                         BUF_DEPTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] ImmOp
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]            count;
  logic [CW-1:0]            outstanding;
  logic [CW-1:0]            drop_cnt;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [PW-1:0]            sq_head;
  logic [PW-1:0]            sq_tail;

  logic [ADDRESS_WIDTH-1:0] buf_pc   [BUF_DEPTH];
  logic [DATA_WIDTH-1:0]    buf_word [BUF_DEPTH];
  logic [ADDRESS_WIDTH-1:0] sq_pc    [BUF_DEPTH];

  logic                     credit_ok;
  logic                     accept;
  logic                     resp;
  logic                     drop;
  logic                     push;
  logic                     pop;
  logic                     redirect;
  logic [ADDRESS_WIDTH-1:0] head_pc;
  logic [ADDRESS_WIDTH-1:0] target;
  logic [CW-1:0]            outstanding_n;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit counts buffered words plus in-flight requests, so a push always has room.
  assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < (CW + 1)'(BUF_DEPTH);
  assign imem_req  = !rst && credit_ok;
  assign imem_addr = fetch_pc;

  assign accept   = imem_req && imem_ready;
  assign resp     = imem_rvalid && (outstanding != '0);
  assign drop     = resp && (drop_cnt != '0);
  assign pop      = instr_valid && instr_ready;
  assign redirect = pop && PCsrc;
  assign push     = resp && !drop && !redirect;

  assign head_pc       = buf_pc[head];
  assign target        = (head_pc + ImmOp) & ~ADDRESS_WIDTH'(3);
  assign outstanding_n = outstanding + CW'(accept) - CW'(resp);

  assign instr_valid = !rst && (count != '0);
  assign instr       = rst ? '0 : buf_word[head];
  assign instr_pc    = rst ? '0 : head_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
      sq_head     <= '0;
      sq_tail     <= '0;
    end else begin
      outstanding <= outstanding_n;
      if (accept) sq_tail <= next_ptr(sq_tail);
      if (resp)   sq_head <= next_ptr(sq_head);
      if (redirect) begin
        // Everything still in flight after this edge belongs to the wrong path.
        fetch_pc <= target;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        drop_cnt <= outstanding_n;
      end else begin
        if (accept) fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
        if (drop)   drop_cnt <= drop_cnt - CW'(1);
        if (push)   tail     <= next_ptr(tail);
        if (pop)    head     <= next_ptr(head);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Data storage carries no reset; validity is tracked by the control state above.
  always_ff @(posedge clk) begin
    if (accept) sq_pc[sq_tail] <= fetch_pc;
    if (push) begin
      buf_pc[tail]   <= sq_pc[sq_head];
      buf_word[tail] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (count == CW'(BUF_DEPTH))))
        else $error("fetch_unit: instruction buffer overflow");
    end
  end

endmodule
